// File: rtl/cursor_controller_pkg.sv
// Shared crossword display types: arrow keycodes, move directions, cursor FSM
// states and default grid geometry.
package crossword_pkg;

    localparam int GRID_N       = 15;
    localparam int CELL_PX      = 32;
    localparam int ORIGIN_X     = 80;
    localparam int ORIGIN_Y     = 0;
    localparam int BLINK_FRAMES = 30;

    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;

    typedef enum logic [2:0] {
        NONE,
        R,
        L,
        D,
        U
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        APPLY
    } cursor_state_t;

    function automatic dir_t key_to_dir(input logic [7:0] code);
        dir_t dir;
        case (code)
            KEY_RIGHT: dir = R;
            KEY_LEFT:  dir = L;
            KEY_DOWN:  dir = D;
            KEY_UP:    dir = U;
            default:   dir = NONE;
        endcase
        return dir;
    endfunction

    function automatic logic [3:0] wrap_inc(input logic [3:0] v, input int n);
        return (int'(v) == n - 1) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] wrap_dec(input logic [3:0] v, input int n);
        return (v == 4'd0) ? 4'(n - 1) : v - 4'd1;
    endfunction

endpackage

// File: rtl/cursor_controller_if.sv
// Keycode valid/ready handshake from the keyboard interface to the cursor.
interface cursor_controller_if;

    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ready;

    modport master (
        output key_valid,
        output key_code,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output key_ready
    );

endinterface

// File: rtl/frame_edge_detect.sv
// Rising-edge pulse on the VGA frame strobe; frame_clk is already in the Clk domain.
module frame_edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_edge
);

    logic frame_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame_clk;
        end
    end

    assign frame_edge = frame_clk & ~frame_q;

endmodule

// File: rtl/cursor_controller.sv
// Crossword grid cursor: accepts arrow keys, applies each move on the next frame
// boundary, and drives the highlight origin and blink phase to color_mapper.
module cursor_controller #(
    parameter int GRID_N       = crossword_pkg::GRID_N,
    parameter int CELL_PX      = crossword_pkg::CELL_PX,
    parameter int ORIGIN_X     = crossword_pkg::ORIGIN_X,
    parameter int ORIGIN_Y     = crossword_pkg::ORIGIN_Y,
    parameter int BLINK_FRAMES = crossword_pkg::BLINK_FRAMES
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_clk,
    cursor_controller_if.slave  key,
    output logic [9:0]          LineX,
    output logic [9:0]          LineY,
    output logic [3:0]          cursor_row,
    output logic [3:0]          cursor_col,
    output logic                cursor_visible
);

    import crossword_pkg::*;

    localparam int CNT_W = ($clog2(BLINK_FRAMES) > 0) ? $clog2(BLINK_FRAMES) : 1;
    localparam int SHIFT = $clog2(CELL_PX);

    cursor_state_t    state_q, state_d;
    dir_t             pend_dir_q, pend_dir_d;
    dir_t             key_dir;
    logic [3:0]       row_q, row_d;
    logic [3:0]       col_q, col_d;
    logic [9:0]       linex_q, linex_d;
    logic [9:0]       liney_q, liney_d;
    logic [CNT_W-1:0] blink_q, blink_d;
    logic             vis_q, vis_d;
    logic             frame_edge;

    frame_edge_detect u_frame_edge (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_edge (frame_edge)
    );

    assign key_dir       = key_to_dir(key.key_code);
    assign key.key_ready = (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        pend_dir_d = pend_dir_q;
        row_d      = row_q;
        col_d      = col_q;
        case (state_q)
            IDLE: begin
                // Non-arrow codes are consumed by the handshake and ignored.
                if (key.key_valid && key_dir != NONE) begin
                    pend_dir_d = key_dir;
                    state_d    = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (frame_edge) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                case (pend_dir_q)
                    R:       col_d = wrap_inc(col_q, GRID_N);
                    L:       col_d = wrap_dec(col_q, GRID_N);
                    D:       row_d = wrap_inc(row_q, GRID_N);
                    U:       row_d = wrap_dec(row_q, GRID_N);
                    default: ;
                endcase
                pend_dir_d = NONE;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        blink_d = blink_q;
        vis_d   = vis_q;
        if (frame_edge) begin
            if (blink_q == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_d = '0;
                vis_d   = ~vis_q;
            end else begin
                blink_d = blink_q + 1'b1;
            end
        end
        // A move always restarts the blink with the highlight shown.
        if (state_q == APPLY) begin
            blink_d = '0;
            vis_d   = 1'b1;
        end
    end

    assign linex_d = 10'(ORIGIN_X) + (10'(col_q) << SHIFT);
    assign liney_d = 10'(ORIGIN_Y) + (10'(row_q) << SHIFT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            pend_dir_q <= NONE;
            row_q      <= '0;
            col_q      <= '0;
            linex_q    <= 10'(ORIGIN_X);
            liney_q    <= 10'(ORIGIN_Y);
            blink_q    <= '0;
            vis_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            pend_dir_q <= pend_dir_d;
            row_q      <= row_d;
            col_q      <= col_d;
            linex_q    <= linex_d;
            liney_q    <= liney_d;
            blink_q    <= blink_d;
            vis_q      <= vis_d;
        end
    end

    assign LineX          = linex_q;
    assign LineY          = liney_q;
    assign cursor_row     = row_q;
    assign cursor_col     = col_q;
    assign cursor_visible = vis_q;

endmodule

// File: tb/tb_cursor_controller.sv
// Self-checking bench for cursor_controller against a frame-level cursor/blink model.
module tb_cursor_controller;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [9:0] LineX, LineY;
    logic [3:0] cursor_row, cursor_col;
    logic       cursor_visible;

    cursor_controller_if kif ();

    cursor_controller #(
        .GRID_N       (15),
        .CELL_PX      (32),
        .ORIGIN_X     (80),
        .ORIGIN_Y     (0),
        .BLINK_FRAMES (30)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .key            (kif),
        .LineX          (LineX),
        .LineY          (LineY),
        .cursor_row     (cursor_row),
        .cursor_col     (cursor_col),
        .cursor_visible (cursor_visible)
    );

    always #5 Clk = ~Clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model: cursor position, frame edges since last restart, pending arrow code.
    int m_row, m_col, m_edges;
    logic [7:0] m_pend;

    function automatic bit is_arrow(input logic [7:0] c);
        return c == 8'h4F || c == 8'h50 || c == 8'h51 || c == 8'h52;
    endfunction

    function automatic int exp_x();
        return 80 + m_col * 32;
    endfunction

    function automatic int exp_y();
        return m_row * 32;
    endfunction

    function automatic logic exp_vis();
        return ((m_edges / 30) % 2) == 0;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0; m_edges = 0; m_pend = 8'h00;
    endtask

    task automatic do_reset();
        Reset = 1'b1; kif.key_valid = 1'b0; kif.key_code = 8'h00; frame_clk = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic send_key(input logic [7:0] c);
        kif.key_valid = 1'b1; kif.key_code = c;
        tick();
        kif.key_valid = 1'b0;
        if (is_arrow(c)) m_pend = c;
    endtask

    task automatic model_move();
        case (m_pend)
            8'h4F: m_col = (m_col + 1) % 15;
            8'h50: m_col = (m_col + 14) % 15;
            8'h51: m_row = (m_row + 1) % 15;
            8'h52: m_row = (m_row + 14) % 15;
            default: ;
        endcase
        if (m_pend != 8'h00) m_edges = 0;
        m_pend = 8'h00;
    endtask

    // One frame edge, then enough idle cycles for any move to reach LineX/LineY.
    task automatic frame();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        m_edges++;
        model_move();
        tick(); tick();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (4) tick();
        total_cnt++; if (LineX !== 10'd80) $display("FAIL reset_LineX got %0d want 80", LineX); else pass_cnt++;
        total_cnt++; if (LineY !== 10'd0) $display("FAIL reset_LineY got %0d want 0", LineY); else pass_cnt++;
        total_cnt++; if ({cursor_row, cursor_col} !== 8'h00) $display("FAIL reset_rowcol got %0d,%0d want 0,0", cursor_row, cursor_col); else pass_cnt++;
        total_cnt++; if (cursor_visible !== 1'b1) $display("FAIL reset_visible got %0b want 1", cursor_visible); else pass_cnt++;
        total_cnt++; if (kif.key_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", kif.key_ready); else pass_cnt++;
    endtask

    task automatic test_move_latency();
        do_reset();
        send_key(8'h4F);
        total_cnt++; if (kif.key_ready !== 1'b0) $display("FAIL lat_ready_drop got %0b want 0", kif.key_ready); else pass_cnt++;
        tick();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        total_cnt++; if (cursor_col !== 4'd0) $display("FAIL lat_col_in_apply got %0d want 0", cursor_col); else pass_cnt++;
        tick();
        total_cnt++; if (cursor_col !== 4'd1) $display("FAIL lat_col_after got %0d want 1", cursor_col); else pass_cnt++;
        total_cnt++; if (kif.key_ready !== 1'b1) $display("FAIL lat_ready_back got %0b want 1", kif.key_ready); else pass_cnt++;
        total_cnt++; if (LineX !== 10'd80) $display("FAIL lat_linex_early got %0d want 80", LineX); else pass_cnt++;
        tick();
        total_cnt++; if (LineX !== 10'd112) $display("FAIL lat_linex got %0d want 112", LineX); else pass_cnt++;
        m_edges = 0; m_col = 1; m_pend = 8'h00;
    endtask

    task automatic test_wrap();
        do_reset();
        send_key(8'h52); frame();
        total_cnt++; if (cursor_row !== 4'(m_row)) $display("FAIL wrap_up_row got %0d want %0d", cursor_row, m_row); else pass_cnt++;
        total_cnt++; if (LineY !== 10'(exp_y())) $display("FAIL wrap_up_liney got %0d want %0d", LineY, exp_y()); else pass_cnt++;
        send_key(8'h50); frame();
        total_cnt++; if (cursor_col !== 4'(m_col)) $display("FAIL wrap_left_col got %0d want %0d", cursor_col, m_col); else pass_cnt++;
        send_key(8'h4F); frame();
        total_cnt++; if (cursor_col !== 4'(m_col)) $display("FAIL wrap_right_col got %0d want %0d", cursor_col, m_col); else pass_cnt++;
        total_cnt++; if (LineX !== 10'(exp_x())) $display("FAIL wrap_right_linex got %0d want %0d", LineX, exp_x()); else pass_cnt++;
        total_cnt++; if (cursor_row !== 4'(m_row)) $display("FAIL wrap_right_row got %0d want %0d", cursor_row, m_row); else pass_cnt++;
    endtask

    task automatic test_non_arrow();
        do_reset();
        send_key(8'h04);
        total_cnt++; if (kif.key_ready !== 1'b1) $display("FAIL nonarrow_ready got %0b want 1", kif.key_ready); else pass_cnt++;
        repeat (3) frame();
        total_cnt++; if ({cursor_row, cursor_col} !== {4'(m_row), 4'(m_col)}) $display("FAIL nonarrow_rowcol got %0d,%0d want %0d,%0d", cursor_row, cursor_col, m_row, m_col); else pass_cnt++;
    endtask

    task automatic test_blink();
        do_reset();
        repeat (29) frame();
        total_cnt++; if (cursor_visible !== exp_vis()) $display("FAIL blink_29 got %0b want %0b", cursor_visible, exp_vis()); else pass_cnt++;
        frame();
        total_cnt++; if (cursor_visible !== exp_vis()) $display("FAIL blink_30 got %0b want %0b", cursor_visible, exp_vis()); else pass_cnt++;
        send_key(8'h51); frame();
        total_cnt++; if (cursor_visible !== exp_vis()) $display("FAIL blink_move got %0b want %0b", cursor_visible, exp_vis()); else pass_cnt++;
        repeat (29) frame();
        total_cnt++; if (cursor_visible !== exp_vis()) $display("FAIL blink_restart_29 got %0b want %0b", cursor_visible, exp_vis()); else pass_cnt++;
        frame();
        total_cnt++; if (cursor_visible !== exp_vis()) $display("FAIL blink_restart_30 got %0b want %0b", cursor_visible, exp_vis()); else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        kif.key_valid = 1'b1; kif.key_code = 8'h4F; frame_clk = 1'b1;
        tick();
        kif.key_valid = 1'b0; frame_clk = 1'b0;
        m_edges++; m_pend = 8'h4F;
        tick(); tick();
        total_cnt++; if (cursor_col !== 4'(m_col)) $display("FAIL same_cycle_nomove got %0d want %0d", cursor_col, m_col); else pass_cnt++;
        total_cnt++; if (kif.key_ready !== 1'b0) $display("FAIL same_cycle_waiting got %0b want 0", kif.key_ready); else pass_cnt++;
        frame();
        total_cnt++; if (cursor_col !== 4'(m_col)) $display("FAIL same_cycle_move got %0d want %0d", cursor_col, m_col); else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        send_key(8'h51); send_key(8'h51);
        frame();
        send_key(8'h4F);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        model_reset();
        total_cnt++; if ({cursor_row, cursor_col} !== 8'h00) $display("FAIL rst_wait_rowcol got %0d,%0d want 0,0", cursor_row, cursor_col); else pass_cnt++;
        total_cnt++; if ({LineX, LineY} !== {10'd80, 10'd0}) $display("FAIL rst_wait_line got %0d,%0d want 80,0", LineX, LineY); else pass_cnt++;
        total_cnt++; if ({kif.key_ready, cursor_visible} !== 2'b11) $display("FAIL rst_wait_ready_vis got %0b want 11", {kif.key_ready, cursor_visible}); else pass_cnt++;
        frame();
        total_cnt++; if ({cursor_row, cursor_col} !== 8'h00) $display("FAIL rst_wait_dropped got %0d,%0d want 0,0", cursor_row, cursor_col); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0] arrows [4] = '{8'h4F, 8'h50, 8'h51, 8'h52};
        logic [7:0] c;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) c = 8'($urandom);
            else c = arrows[$urandom_range(0, 3)];
            total_cnt++; if (kif.key_ready !== 1'b1) $display("FAIL rand_ready[%0d] got %0b want 1", i, kif.key_ready); else pass_cnt++;
            send_key(c);
            frame();
            repeat ($urandom_range(0, 3)) frame();
            total_cnt++; if ({cursor_row, cursor_col} !== {4'(m_row), 4'(m_col)}) $display("FAIL rand_rowcol[%0d] key %h got %0d,%0d want %0d,%0d", i, c, cursor_row, cursor_col, m_row, m_col); else pass_cnt++;
            total_cnt++; if ({LineX, LineY} !== {10'(exp_x()), 10'(exp_y())}) $display("FAIL rand_line[%0d] got %0d,%0d want %0d,%0d", i, LineX, LineY, exp_x(), exp_y()); else pass_cnt++;
            total_cnt++; if (cursor_visible !== exp_vis()) $display("FAIL rand_visible[%0d] got %0b want %0b", i, cursor_visible, exp_vis()); else pass_cnt++;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        kif.key_valid = 1'b0;
        kif.key_code  = 8'h00;
        test_reset();
        test_move_latency();
        test_wrap();
        test_non_arrow();
        test_blink();
        test_same_cycle();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
